// File: rtl/cpu_defs_pkg.sv
// Shared CPU-side constants: joypad button bit positions and debounce defaults.
// Imported by the joypad input-conditioning blocks.
package cpu_defs;

    localparam int JP_RIGHT  = 0;
    localparam int JP_LEFT   = 1;
    localparam int JP_UP     = 2;
    localparam int JP_DOWN   = 3;
    localparam int JP_A      = 4;
    localparam int JP_B      = 5;
    localparam int JP_SELECT = 6;
    localparam int JP_START  = 7;

    localparam int JP_NUM_BTNS         = 8;
    localparam int JP_DEBOUNCE_DEFAULT = 50000;

    // Counter width for a debounce window; never narrower than one bit.
    function automatic int jp_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit_m.sv
// One button line: two-flop synchronizer, stability counter and the debounced level.
// stable_nxt_o exposes the next-state level so the parent can edge-detect without extra latency.
module debounce_bit_m
    import cpu_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = JP_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic stable_o,
    output logic stable_nxt_o
);

    localparam int              CW   = jp_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any cycle where the synchronized level matches the current output drops all credit.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s2_q != stable_q) begin
            if (cnt_q == TERM) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            s1_q     <= raw_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o     = stable_q;
    assign stable_nxt_o = stable_d;

endmodule

// File: rtl/joypad_debounce_m.sv
// Joypad input conditioning: eight debounced active-low buttons plus a one-cycle
// interrupt request on any debounced press (1->0 on je).
module joypad_debounce_m
    import cpu_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = JP_DEBOUNCE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [JP_NUM_BTNS-1:0] btn_raw,
    output logic [JP_NUM_BTNS-1:0] je,
    output logic                   irq_joypad
);

    logic [JP_NUM_BTNS-1:0] je_q;
    logic [JP_NUM_BTNS-1:0] je_d;
    logic                   irq_q, irq_d;

    for (genvar gi = 0; gi < JP_NUM_BTNS; gi++) begin : g_bit
        debounce_bit_m #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk          (clk),
            .rst          (rst),
            .raw_i        (btn_raw[gi]),
            .stable_o     (je_q[gi]),
            .stable_nxt_o (je_d[gi])
        );
    end

    // Registered alongside je so the pulse coincides with the first cycle showing the press.
    assign irq_d = |(je_q & ~je_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign je         = je_q;
    assign irq_joypad = irq_q;

endmodule

// File: tb/tb_joypad_debounce_m.sv
// Self-checking bench for joypad_debounce_m with a sliding-window reference model.
module tb_joypad_debounce_m;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] btn_raw;
    logic [7:0] je;
    logic       irq_joypad;

    int tests  = 0;
    int failed = 0;

    joypad_debounce_m #(.DEBOUNCE_CYCLES(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .je         (je),
        .irq_joypad (irq_joypad)
    );

    always #5 clk = ~clk;

    // Model: a bit adopts level v once the last D synchronized samples all read v.
    logic [7:0] m_s1, m_s2, m_je;
    logic       m_irq;
    logic [7:0] m_hist[$];

    task automatic model_edge(input logic [7:0] r, input logic rs);
        logic [7:0] nje;
        if (rs) begin
            m_s1 = 8'hFF; m_s2 = 8'hFF; m_je = 8'hFF; m_irq = 1'b0;
            m_hist.delete();
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            nje = m_je;
            if (m_hist.size() == D) begin
                for (int i = 0; i < 8; i++) begin
                    logic v;
                    logic same;
                    v = m_hist[0][i];
                    same = 1'b1;
                    for (int j = 0; j < D; j++) if (m_hist[j][i] != v) same = 1'b0;
                    if (same && v != m_je[i]) nje[i] = v;
                end
            end
            m_irq = |(m_je & ~nje);
            m_je  = nje;
            m_s2  = m_s1;
            m_s1  = r;
        end
    endtask

    // Drive at negedge, take one rising edge, return at the following negedge.
    task automatic step(input logic [7:0] r, input logic rs);
        btn_raw = r;
        rst     = rs;
        @(posedge clk);
        model_edge(r, rs);
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int n = 0; n < 3; n++) begin
            step(8'h00, 1'b1);
            tests++;
            if (je !== 8'hFF || irq_joypad !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold: je=%h irq=%b want je=ff irq=0", je, irq_joypad);
            end
        end
        for (int n = 1; n <= 8; n++) begin
            step(8'h00, 1'b0);
            tests++;
            if (je !== ((n >= 6) ? 8'h00 : 8'hFF) || irq_joypad !== (n == 6)) begin
                failed++;
                $display("FAIL reset_release n=%0d: je=%h irq=%b want je=%h irq=%b",
                         n, je, irq_joypad, (n >= 6) ? 8'h00 : 8'hFF, n == 6);
            end
        end
    endtask

    task automatic test_press_release();
        for (int n = 0; n < 8; n++) step(8'hFF, 1'b0);
        tests++;
        if (je !== 8'hFF) begin
            failed++;
            $display("FAIL settle_release: je=%h want ff", je);
        end
        for (int n = 1; n <= 7; n++) begin
            step(8'hEF, 1'b0);
            tests++;
            if (je !== ((n >= 6) ? 8'hEF : 8'hFF) || irq_joypad !== (n == 6)) begin
                failed++;
                $display("FAIL press_a n=%0d: je=%h irq=%b want je=%h irq=%b",
                         n, je, irq_joypad, (n >= 6) ? 8'hEF : 8'hFF, n == 6);
            end
        end
        for (int n = 1; n <= 7; n++) begin
            step(8'hFF, 1'b0);
            tests++;
            if (je !== ((n >= 6) ? 8'hFF : 8'hEF) || irq_joypad !== 1'b0) begin
                failed++;
                $display("FAIL release_a n=%0d: je=%h irq=%b want je=%h irq=0",
                         n, je, irq_joypad, (n >= 6) ? 8'hFF : 8'hEF);
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat[14];
        int pulses;
        pulses = 0;
        for (int n = 0; n < 14; n++) pat[n] = (n < 3 || n >= 4) ? 8'hFE : 8'hFF;
        for (int n = 1; n <= 14; n++) begin
            step(pat[n-1], 1'b0);
            if (irq_joypad === 1'b1) pulses++;
            tests++;
            if (je[0] !== ((n >= 10) ? 1'b0 : 1'b1)) begin
                failed++;
                $display("FAIL bounce n=%0d: je0=%b want %b", n, je[0], n < 10);
            end
        end
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL bounce_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        for (int n = 0; n < 8; n++) step(8'hFF, 1'b0);
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            step(8'h7B, 1'b0);
            if (irq_joypad === 1'b1) pulses++;
            tests++;
            if (je !== ((n >= 6) ? 8'h7B : 8'hFF)) begin
                failed++;
                $display("FAIL simul_press n=%0d: je=%h want %h", n, je, (n >= 6) ? 8'h7B : 8'hFF);
            end
        end
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL simul_press_pulses: got %0d want 1", pulses);
        end
        pulses = 0;
        for (int n = 1; n <= 8; n++) begin
            step(8'h77, 1'b0);
            if (irq_joypad === 1'b1) pulses++;
            tests++;
            if (je !== ((n >= 6) ? 8'h77 : 8'h7B)) begin
                failed++;
                $display("FAIL simul_swap n=%0d: je=%h want %h", n, je, (n >= 6) ? 8'h77 : 8'h7B);
            end
        end
        tests++;
        if (pulses != 1) begin
            failed++;
            $display("FAIL simul_swap_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) step(8'hFF, 1'b0);
        step(8'hFD, 1'b0);
        for (int n = 2; n <= 9; n++) begin
            step(8'hDD, 1'b0);
            tests++;
            if (irq_joypad !== (n == 6 || n == 7)) begin
                failed++;
                $display("FAIL b2b n=%0d: irq=%b want %b", n, irq_joypad, n == 6 || n == 7);
            end
        end
        tests++;
        if (je !== 8'hDD) begin
            failed++;
            $display("FAIL b2b_je: je=%h want dd", je);
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 0; n < 8; n++) step(8'hFF, 1'b0);
        for (int n = 0; n < 3; n++) step(8'hBF, 1'b0);
        step(8'hBF, 1'b1);
        tests++;
        if (je !== 8'hFF || irq_joypad !== 1'b0) begin
            failed++;
            $display("FAIL mid_reset: je=%h irq=%b want je=ff irq=0", je, irq_joypad);
        end
        for (int n = 1; n <= 7; n++) begin
            step(8'hBF, 1'b0);
            tests++;
            if (je !== ((n >= 6) ? 8'hBF : 8'hFF) || irq_joypad !== (n == 6)) begin
                failed++;
                $display("FAIL mid_redetect n=%0d: je=%h irq=%b want je=%h irq=%b",
                         n, je, irq_joypad, (n >= 6) ? 8'hBF : 8'hFF, n == 6);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       rs;
        r = 8'hFF;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 8; i++) if ($urandom_range(0, 9) == 0) r[i] = ~r[i];
            rs = ($urandom_range(0, 299) == 0);
            step(r, rs);
            tests++;
            if (je !== m_je || irq_joypad !== m_irq) begin
                failed++;
                $display("FAIL random cyc=%0d: je=%h irq=%b want je=%h irq=%b",
                         n, je, irq_joypad, m_je, m_irq);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        btn_raw = 8'hFF;
        m_s1 = 8'hFF; m_s2 = 8'hFF; m_je = 8'hFF; m_irq = 1'b0;
        @(negedge clk);
        test_reset();
        test_press_release();
        test_bounce();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
